// File: rtl/ulpi_phy_reg_responder_if.sv
// ULPI bus between a link (master) and the PHY register responder (slave).
interface ulpi_phy_reg_responder_if;
    logic [7:0] linkData;
    logic       stp;
    logic [7:0] phyData;
    logic       phyDataOe;
    logic       dir;
    logic       nxt;

    modport master (output linkData, stp, input phyData, phyDataOe, dir, nxt);
    modport slave  (input linkData, stp, output phyData, phyDataOe, dir, nxt);
endinterface

// File: rtl/ulpi_phy_reg_responder.sv
// PHY-side ULPI register responder: TX CMD register read/write with DIR turnaround,
// a small PHY register file, and RX CMD reporting of line/VBUS state changes.
module ulpi_phy_reg_responder #(
    parameter logic [15:0] VENDOR_ID    = 16'h0424,
    parameter logic [15:0] PRODUCT_ID   = 16'h0009,
    parameter logic [7:0]  FUN_CTRL_RST = 8'h41,
    parameter logic [7:0]  OTG_CTRL_RST = 8'h06
) (
    input  logic                          clk,
    input  logic                          rst,
    ulpi_phy_reg_responder_if.slave       io_ulpi,
    input  logic [1:0]                    i_lineState,
    input  logic [1:0]                    i_vbusState,
    output logic [7:0]                    o_funCtrl,
    output logic [7:0]                    o_otgCtrl,
    output logic [7:0]                    o_scratch
);

    typedef enum logic [2:0] {
        IDLE, CMD_ACK, WR_DATA, WR_STP, RD_TA, RD_DATA, RX_TA, RX_DATA
    } state_t;

    state_t     r_state;
    logic [5:0] r_addr;
    logic       r_isRead;
    logic [7:0] r_wdata;
    logic [7:0] r_funCtrl;
    logic [7:0] r_ifcCtrl;
    logic [7:0] r_otgCtrl;
    logic [7:0] r_scratch;
    logic [3:0] r_snapshot;
    logic       r_rxPending;
    logic [7:0] r_dataO;
    logic       r_oe;
    logic       r_dir;
    logic       r_nxt;

    logic [3:0] w_lineBits;
    logic       w_stateChange;
    logic       w_isCmd;
    logic       w_commit;
    logic [7:0] w_readData;
    logic       w_hitFun;
    logic       w_hitIfc;
    logic       w_hitOtg;
    logic       w_hitScr;
    logic [1:0] w_op;

    assign w_lineBits    = {i_vbusState, i_lineState};
    assign w_stateChange = (w_lineBits != r_snapshot);
    // Extended-register command (addr 2F) is deliberately not recognised as a command.
    assign w_isCmd       = io_ulpi.linkData[7] && (io_ulpi.linkData[5:0] != 6'h2F);
    assign w_commit      = (r_state == WR_STP) && io_ulpi.stp;

    function automatic logic [7:0] applyOp(input logic [7:0] cur, input logic [7:0] d,
                                           input logic [1:0] op);
        case (op)
            2'd0:    applyOp = d;
            2'd1:    applyOp = cur | d;
            default: applyOp = cur & ~d;
        endcase
    endfunction

    always_comb begin
        w_hitFun = 1'b0;
        w_hitIfc = 1'b0;
        w_hitOtg = 1'b0;
        w_hitScr = 1'b0;
        w_op     = 2'd0;
        if (r_addr inside {[6'h04:6'h06]}) begin
            w_hitFun = 1'b1;
            w_op     = 2'(r_addr - 6'h04);
        end else if (r_addr inside {[6'h07:6'h09]}) begin
            w_hitIfc = 1'b1;
            w_op     = 2'(r_addr - 6'h07);
        end else if (r_addr inside {[6'h0A:6'h0C]}) begin
            w_hitOtg = 1'b1;
            w_op     = 2'(r_addr - 6'h0A);
        end else if (r_addr inside {[6'h16:6'h18]}) begin
            w_hitScr = 1'b1;
            w_op     = 2'(r_addr - 6'h16);
        end
    end

    always_comb begin
        w_readData = 8'h00;
        case (r_addr)
            6'h00:   w_readData = VENDOR_ID[7:0];
            6'h01:   w_readData = VENDOR_ID[15:8];
            6'h02:   w_readData = PRODUCT_ID[7:0];
            6'h03:   w_readData = PRODUCT_ID[15:8];
            default: begin
                if (w_hitFun)      w_readData = r_funCtrl;
                else if (w_hitIfc) w_readData = r_ifcCtrl;
                else if (w_hitOtg) w_readData = r_otgCtrl;
                else if (w_hitScr) w_readData = r_scratch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= 6'h00;
            r_isRead    <= 1'b0;
            r_wdata     <= 8'h00;
            r_funCtrl   <= FUN_CTRL_RST;
            r_ifcCtrl   <= 8'h00;
            r_otgCtrl   <= OTG_CTRL_RST;
            r_scratch   <= 8'h00;
            r_snapshot  <= {i_vbusState, i_lineState};
            r_rxPending <= 1'b0;
            r_dataO     <= 8'h00;
            r_oe        <= 1'b0;
            r_dir       <= 1'b0;
            r_nxt       <= 1'b0;
        end else begin
            if (r_funCtrl[5]) r_funCtrl[5] <= 1'b0;
            if (w_commit) begin
                if (w_hitFun) r_funCtrl <= applyOp(r_funCtrl, r_wdata, w_op);
                if (w_hitIfc) r_ifcCtrl <= applyOp(r_ifcCtrl, r_wdata, w_op);
                if (w_hitOtg) r_otgCtrl <= applyOp(r_otgCtrl, r_wdata, w_op);
                if (w_hitScr) r_scratch <= applyOp(r_scratch, r_wdata, w_op);
            end
            if (w_stateChange) begin
                r_snapshot  <= w_lineBits;
                r_rxPending <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_isCmd) begin
                        r_state  <= CMD_ACK;
                        r_addr   <= io_ulpi.linkData[5:0];
                        r_isRead <= io_ulpi.linkData[6];
                        r_nxt    <= 1'b1;
                    end else if (r_rxPending) begin
                        r_state <= RX_TA;
                        r_dir   <= 1'b1;
                        r_oe    <= 1'b0;
                    end
                end
                CMD_ACK: begin
                    if (r_isRead) begin
                        r_state <= RD_TA;
                        r_nxt   <= 1'b0;
                        r_dir   <= 1'b1;
                        r_oe    <= 1'b0;
                    end else begin
                        r_state <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    r_nxt <= 1'b0;
                    if (io_ulpi.stp) begin
                        r_state <= IDLE;
                    end else begin
                        r_wdata <= io_ulpi.linkData;
                        r_state <= WR_STP;
                    end
                end
                WR_STP: begin
                    if (io_ulpi.stp) r_state <= IDLE;
                end
                RD_TA: begin
                    r_state <= RD_DATA;
                    r_oe    <= 1'b1;
                    r_dataO <= w_readData;
                end
                RX_TA: begin
                    r_state <= RX_DATA;
                    r_oe    <= 1'b1;
                    r_dataO <= {4'b0000, r_snapshot};
                    // A change landing on this same edge must survive as a fresh RX CMD.
                    if (!w_stateChange) r_rxPending <= 1'b0;
                end
                RD_DATA, RX_DATA: begin
                    r_state <= IDLE;
                    r_dir   <= 1'b0;
                    r_oe    <= 1'b0;
                    r_dataO <= 8'h00;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_ulpi.phyData   = r_dataO;
    assign io_ulpi.phyDataOe = r_oe;
    assign io_ulpi.dir       = r_dir;
    assign io_ulpi.nxt       = r_nxt;
    assign o_funCtrl         = r_funCtrl;
    assign o_otgCtrl         = r_otgCtrl;
    assign o_scratch         = r_scratch;

endmodule

// File: tb/tb_ulpi_phy_reg_responder.sv
// Directed bench for the ULPI PHY register responder; inputs driven and outputs
// checked on the falling clock edge.
module tb_ulpi_phy_reg_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] lineState;
    logic [1:0] vbusState;
    logic [7:0] funCtrl;
    logic [7:0] otgCtrl;
    logic [7:0] scratch;
    int         checkCount = 0;
    int         passCount  = 0;

    ulpi_phy_reg_responder_if ulpiBus();

    ulpi_phy_reg_responder dut (
        .clk         (clk),
        .rst         (rst),
        .io_ulpi     (ulpiBus),
        .i_lineState (lineState),
        .i_vbusState (vbusState),
        .o_funCtrl   (funCtrl),
        .o_otgCtrl   (otgCtrl),
        .o_scratch   (scratch)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stp);
        ulpiBus.linkData = data;
        ulpiBus.stp      = stp;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic checkBus(input string tag, input logic dir, input logic nxt, input logic oe,
                            input logic [7:0] data);
        checkOutput({tag, ".dir"},  {7'b0, ulpiBus.dir},       {7'b0, dir});
        checkOutput({tag, ".nxt"},  {7'b0, ulpiBus.nxt},       {7'b0, nxt});
        checkOutput({tag, ".oe"},   {7'b0, ulpiBus.phyDataOe}, {7'b0, oe});
        checkOutput({tag, ".data"}, ulpiBus.phyData,           data);
    endtask

    // Starts and ends on a falling edge with the DUT idle.
    task automatic doRead(input string tag, input logic [5:0] addr, input logic [7:0] expected);
        applyStimulus({2'b11, addr}, 1'b0);
        nextCycle();
        checkBus({tag, ".ack"}, 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(8'h00, 1'b0);
        nextCycle();
        checkBus({tag, ".ta"}, 1'b1, 1'b0, 1'b0, 8'h00);
        nextCycle();
        checkBus({tag, ".rd"}, 1'b1, 1'b0, 1'b1, expected);
        nextCycle();
        checkBus({tag, ".end"}, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic doWrite(input string tag, input logic [7:0] cmd, input logic [7:0] data,
                           input logic abort);
        applyStimulus(cmd, 1'b0);
        nextCycle();
        checkOutput({tag, ".nxt1"}, {7'b0, ulpiBus.nxt}, 8'h01);
        applyStimulus(data, 1'b0);
        nextCycle();
        checkOutput({tag, ".nxt2"}, {7'b0, ulpiBus.nxt}, 8'h01);
        if (abort) applyStimulus(data, 1'b1);
        nextCycle();
        checkOutput({tag, ".nxt3"}, {7'b0, ulpiBus.nxt}, 8'h00);
        applyStimulus(8'h00, !abort);
        if (!abort) begin
            nextCycle();
            applyStimulus(8'h00, 1'b0);
        end
    endtask

    // Caller has just changed lineState/vbusState on a falling edge.
    task automatic doRxCheck(input string tag, input logic [7:0] expected);
        nextCycle();
        checkBus({tag, ".pend"}, 1'b0, 1'b0, 1'b0, 8'h00);
        nextCycle();
        checkBus({tag, ".ta"}, 1'b1, 1'b0, 1'b0, 8'h00);
        nextCycle();
        checkBus({tag, ".rx"}, 1'b1, 1'b0, 1'b1, expected);
        nextCycle();
        checkBus({tag, ".end"}, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst       = 1'b1;
        lineState = 2'b00;
        vbusState = 2'b00;
        applyStimulus(8'h00, 1'b0);
        repeat (3) nextCycle();
        rst = 1'b0;
        nextCycle();
        checkBus("reset", 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("reset.fun", funCtrl, 8'h41);
        checkOutput("reset.otg", otgCtrl, 8'h06);
        checkOutput("reset.scr", scratch, 8'h00);

        doRead("rdVidLo", 6'h00, 8'h24);
        doRead("rdVidHi", 6'h01, 8'h04);
        doRead("rdPidLo", 6'h02, 8'h09);
        doRead("rdOtg",   6'h0A, 8'h06);
        doRead("rdUnmap", 6'h20, 8'h00);

        doWrite("wrScr", 8'h96, 8'hA5, 1'b0);
        checkOutput("wrScr.val", scratch, 8'hA5);
        doWrite("setScr", 8'h97, 8'h0F, 1'b0);
        checkOutput("setScr.val", scratch, 8'hAF);
        doWrite("clrScr", 8'h98, 8'hA0, 1'b0);
        checkOutput("clrScr.val", scratch, 8'h0F);
        doRead("rdScrClr", 6'h18, 8'h0F);

        doWrite("wrFun", 8'h84, 8'h60, 1'b0);
        checkOutput("wrFun.val", funCtrl, 8'h60);
        nextCycle();
        checkOutput("wrFun.selfClr", funCtrl, 8'h40);

        doWrite("setOtg", 8'h8B, 8'h01, 1'b0);
        checkOutput("setOtg.val", otgCtrl, 8'h07);

        doWrite("abortScr", 8'h96, 8'h33, 1'b1);
        checkOutput("abortScr.val", scratch, 8'h0F);
        nextCycle();
        doRead("rdAfterAbort", 6'h16, 8'h0F);

        applyStimulus(8'hEF, 1'b0);
        nextCycle();
        checkOutput("ext.nxt1", {7'b0, ulpiBus.nxt}, 8'h00);
        nextCycle();
        checkBus("ext.idle", 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h00, 1'b0);
        nextCycle();

        lineState = 2'b01;
        doRxCheck("rxLs", 8'h01);
        vbusState = 2'b11;
        doRxCheck("rxVbus", 8'h0D);

        // Two line changes inside a read coalesce into one RX CMD carrying the last state.
        applyStimulus(8'hCA, 1'b0);
        nextCycle();
        checkBus("coal.ack", 1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(8'h00, 1'b0);
        lineState = 2'b10;
        nextCycle();
        checkBus("coal.ta", 1'b1, 1'b0, 1'b0, 8'h00);
        lineState = 2'b11;
        nextCycle();
        checkBus("coal.rd", 1'b1, 1'b0, 1'b1, 8'h07);
        nextCycle();
        checkBus("coal.rdEnd", 1'b0, 1'b0, 1'b0, 8'h00);
        nextCycle();
        checkBus("coal.rxTa", 1'b1, 1'b0, 1'b0, 8'h00);
        nextCycle();
        checkBus("coal.rx", 1'b1, 1'b0, 1'b1, 8'h0F);
        nextCycle();
        checkBus("coal.rxEnd", 1'b0, 1'b0, 1'b0, 8'h00);
        nextCycle();
        checkOutput("coal.noSecond1", {7'b0, ulpiBus.dir}, 8'h00);
        nextCycle();
        checkOutput("coal.noSecond2", {7'b0, ulpiBus.dir}, 8'h00);

        applyStimulus(8'h96, 1'b0);
        nextCycle();
        applyStimulus(8'h33, 1'b0);
        nextCycle();
        rst = 1'b1;
        #2;
        checkOutput("rstMid.dir", {7'b0, ulpiBus.dir}, 8'h00);
        checkOutput("rstMid.nxt", {7'b0, ulpiBus.nxt}, 8'h00);
        checkOutput("rstMid.scr", scratch, 8'h00);
        checkOutput("rstMid.fun", funCtrl, 8'h41);
        checkOutput("rstMid.otg", otgCtrl, 8'h06);
        nextCycle();
        rst = 1'b0;
        applyStimulus(8'h00, 1'b1);
        nextCycle();
        applyStimulus(8'h00, 1'b0);
        nextCycle();
        checkBus("rstAfter", 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rstAfter.scr", scratch, 8'h00);
        doRead("rdAfterRst", 6'h16, 8'h00);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
